store_buffer: RTL and testbench

Write buffer between the pipeline's memory stage and the word-addressed data memory. Accepts stores in one cycle, queues them in order in a small FIFO, and drains one store per cycle into the memory's single write port. Loads go to the same single-address memory: the buffer forwards the youngest matching queued store, or hands the memory address port to the load and pauses draining for that cycle.

---
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Write buffer between the memory stage and a word-addressed data memory
//   with a single address port. Stores are accepted in one cycle into a small
//   circular FIFO and drained one per cycle into the memory write port, oldest
//   first. A load is answered from the youngest matching buffered store when
//   one exists. Otherwise the load takes the memory address port for that cycle
//   and draining pauses.
//
// Parameters
//   DEPTH   number of store entries (power of two, >= 2)
//   ADDR_W  word address width
//   DATA_W  data width
//
// Ports
//   clk, rst                rising-edge clock, synchronous active-high reset
//   storeReq/Addr/Data      store request from the pipeline
//   storeReady              buffer has a free entry this cycle
//   loadReq/loadAddr        load request from the pipeline
//   loadData, loadHit       load result (forwarded entry or memRdata) and hit flag
//   memWrite, memAddress,   memory write strobe, address and write data
//   memDataIn
//   memRdata                combinational memory read data
//   empty                   no stores pending
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              storeReq,
  input  logic [ADDR_W-1:0] storeAddr,
  input  logic [DATA_W-1:0] storeData,
  output logic              storeReady,
  input  logic              loadReq,
  input  logic [ADDR_W-1:0] loadAddr,
  output logic [DATA_W-1:0] loadData,
  output logic              loadHit,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memRdata,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic              enq;
  logic              drain;
  logic              conflict;
  logic              hitAny;
  logic [DATA_W-1:0] fwdData;
  logic [PTR_W-1:0]  searchIdx;

  assign storeReady = (count < FULL_COUNT);
  assign empty      = (count == '0);
  assign enq        = storeReq && storeReady;

  // Forwarding search. Entries are walked from oldest (head) to youngest,
  // and a later match overwrites an earlier one, so the youngest matching
  // store wins. Walking by offset from head handles the pointer wrap without
  // any special case. A store enqueued this cycle is not yet in the array,
  // so the load cannot see it.
  always_comb begin
    hitAny    = 1'b0;
    fwdData   = '0;
    searchIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      searchIdx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (entryAddr[searchIdx] == loadAddr)) begin
        hitAny  = 1'b1;
        fwdData = entryData[searchIdx];
      end
    end
  end

  // Port arbitration. A missing load needs the memory address port, so it
  // wins that cycle and the drain waits. A hitting load never touches memory,
  // so draining continues alongside it. The write strobe is also held low
  // while in reset.
  always_comb begin
    loadHit    = loadReq && hitAny;
    loadData   = loadHit ? fwdData : memRdata;
    conflict   = loadReq && !hitAny;
    drain      = !rst && (count != '0) && !conflict;
    memWrite   = drain;
    memAddress = conflict ? loadAddr : entryAddr[head];
    memDataIn  = entryData[head];
  end

  // Entry storage holds no reset. Validity comes only from head/count, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      entryAddr[tail] <= storeAddr;
      entryData[tail] <= storeData;
    end
  end

  // Pointer and occupancy bookkeeping. The pointers wrap naturally at their
  // width. An enqueue and a drain on the same edge leave the count unchanged.
  // This keeps one store per cycle of throughput in steady state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Self-checking bench for store_buffer. A queue-based model of the pending
//   stores and a model memory predict every output each cycle. Directed
//   scenarios add literal expectations, and a long randomized phase follows.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              storeReq = 1'b0;
  logic [ADDR_W-1:0] storeAddr = '0;
  logic [DATA_W-1:0] storeData = '0;
  logic              storeReady;
  logic              loadReq = 1'b0;
  logic [ADDR_W-1:0] loadAddr = '0;
  logic [DATA_W-1:0] loadData;
  logic              loadHit;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memDataIn;
  logic [DATA_W-1:0] memRdata;
  logic              empty;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            q[$];
  logic [DATA_W-1:0] refMem [256];
  logic [DATA_W-1:0] tbMem  [256];

  logic              wrPending = 1'b0;
  logic [7:0]        wrAddr = '0;
  logic [DATA_W-1:0] wrData = '0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .storeReq   (storeReq),
    .storeAddr  (storeAddr),
    .storeData  (storeData),
    .storeReady (storeReady),
    .loadReq    (loadReq),
    .loadAddr   (loadAddr),
    .loadData   (loadData),
    .loadHit    (loadHit),
    .memWrite   (memWrite),
    .memAddress (memAddress),
    .memDataIn  (memDataIn),
    .memRdata   (memRdata),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // The bench plays the data memory: combinational read, write on the edge.
  assign memRdata = tbMem[memAddress[7:0]];

  always @(posedge clk) begin
    if (wrPending) begin
      tbMem[wrAddr] <= wrData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest matching pending store, searched from the back of the queue.
  task automatic modelLookup(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr == a) begin
        h = 1'b1;
        d = q[i].data;
        break;
      end
    end
  endtask

  task automatic modelPredict(output logic expHit, output logic [DATA_W-1:0] expLoad,
                              output logic expConflict, output logic expDrain);
    logic h;
    logic [DATA_W-1:0] d;
    modelLookup(loadAddr, h, d);
    expHit      = loadReq && h;
    expLoad     = expHit ? d : refMem[loadAddr[7:0]];
    expConflict = loadReq && !h;
    expDrain    = !rst && (q.size() > 0) && !expConflict;
  endtask

  // Per-cycle compare against the model, at mid-cycle with inputs stable.
  // It also captures the write the memory will take on the next edge.
  always @(negedge clk) begin
    logic eHit, eConf, eDrain;
    logic [DATA_W-1:0] eLoad;
    wrPending <= memWrite;
    wrAddr    <= memAddress[7:0];
    wrData    <= memDataIn;
    if (checkEn) begin
      modelPredict(eHit, eLoad, eConf, eDrain);
      checkOutput("storeReady", 32'(storeReady), 32'(q.size() < DEPTH));
      checkOutput("empty", 32'(empty), 32'(q.size() == 0));
      checkOutput("memWrite", 32'(memWrite), 32'(eDrain));
      checkOutput("loadHit", 32'(loadHit), 32'(eHit));
      if (eConf) checkOutput("memAddress(load)", memAddress, loadAddr);
      else if (q.size() > 0) checkOutput("memAddress(head)", memAddress, q[0].addr);
      if (eDrain) checkOutput("memDataIn", memDataIn, q[0].data);
      if (loadReq) checkOutput("loadData", loadData, eLoad);
    end
  end

  // Model state advance on the edge. Acceptance uses the occupancy before
  // this edge's drain, so a full buffer cannot refill in the same cycle.
  always @(posedge clk) begin
    logic eHit, eConf, eDrain;
    logic [DATA_W-1:0] eLoad;
    logic accept;
    if (checkEn || rst) begin
      modelPredict(eHit, eLoad, eConf, eDrain);
      if (rst) begin
        q.delete();
      end else begin
        accept = storeReq && (q.size() < DEPTH);
        if (eDrain) begin
          refMem[q[0].addr[7:0]] = q[0].data;
          void'(q.pop_front());
        end
        if (accept) q.push_back('{addr: storeAddr, data: storeData});
      end
    end
  end

  // One cycle of stimulus. Inputs change just after the edge and stay put
  // until the next one. The task returns at mid-cycle for literal checks.
  task automatic applyStimulus(input logic sReq, input logic [31:0] sAddr, input logic [31:0] sData,
                               input logic lReq, input logic [31:0] lAddr, input logic r);
    @(posedge clk);
    #1;
    storeReq  = sReq;
    storeAddr = sAddr;
    storeData = sData;
    loadReq   = lReq;
    loadAddr  = lAddr;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbMem[i]  = '0;
      refMem[i] = '0;
    end
    tbMem[3]  = 32'h77;
    refMem[3] = 32'h77;

    // Reset, then the single store at address 5.
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("memWrite in reset", 32'(memWrite), 0);
    idle();
    checkEn = 1'b1;
    checkOutput("reset storeReady", 32'(storeReady), 1);
    checkOutput("reset empty", 32'(empty), 1);
    checkOutput("reset memWrite", 32'(memWrite), 0);
    checkOutput("reset loadHit", 32'(loadHit), 0);
    applyStimulus(1'b1, 5, 32'hAA, 1'b0, 0, 1'b0);
    idle();
    checkOutput("single memWrite", 32'(memWrite), 1);
    checkOutput("single memAddress", memAddress, 5);
    checkOutput("single memDataIn", memDataIn, 32'hAA);
    idle();
    checkOutput("single empty after", 32'(empty), 1);

    // Fill while a missing load starves the drain.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 20 + i, 32'h200 + i, 1'b1, 100, 1'b0);
      checkOutput("fill storeReady", 32'(storeReady), (i < 4) ? 1 : 0);
      checkOutput("fill memWrite", 32'(memWrite), 0);
      checkOutput("fill memAddress", memAddress, 100);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("fill drain memWrite", 32'(memWrite), 1);
      checkOutput("fill drain memAddress", memAddress, 20 + i);
      checkOutput("fill drain memDataIn", memDataIn, 32'h200 + i);
    end
    idle();
    checkOutput("fill drained empty", 32'(empty), 1);

    // Duplicate address: the youngest store must be forwarded.
    applyStimulus(1'b1, 8, 32'h11, 1'b1, 100, 1'b0);
    applyStimulus(1'b1, 8, 32'h22, 1'b1, 100, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 8, 1'b0);
    checkOutput("fwd loadHit", 32'(loadHit), 1);
    checkOutput("fwd loadData", loadData, 32'h22);
    checkOutput("fwd memWrite", 32'(memWrite), 1);
    checkOutput("fwd memDataIn", memDataIn, 32'h11);
    idle();
    idle();

    // Load miss to memory with two entries pending.
    applyStimulus(1'b1, 30, 32'h300, 1'b1, 100, 1'b0);
    applyStimulus(1'b1, 31, 32'h301, 1'b1, 100, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1'b0);
    checkOutput("miss loadHit", 32'(loadHit), 0);
    checkOutput("miss loadData", loadData, 32'h77);
    checkOutput("miss memWrite", 32'(memWrite), 0);
    idle();
    checkOutput("miss drain0 addr", memAddress, 30);
    idle();
    checkOutput("miss drain1 addr", memAddress, 31);
    idle();
    checkOutput("miss drained memWrite", 32'(memWrite), 0);
    checkOutput("miss drained empty", 32'(empty), 1);

    // Reset with three stores pending: nothing more may be written.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 60 + i, 32'h600 + i, 1'b1, 100, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
    checkOutput("midreset memWrite", 32'(memWrite), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("postreset empty", 32'(empty), 1);
      checkOutput("postreset storeReady", 32'(storeReady), 1);
      checkOutput("postreset memWrite", 32'(memWrite), 0);
    end

    // Wrap-around from a fresh head/tail of 0: ten back-to-back stores.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 40 + i, 32'h400 + i, 1'b0, 0, 1'b0);
      if (i > 0) checkOutput("wrap drain addr", memAddress, 40 + i - 1);
      if (i > 0) checkOutput("wrap drain memWrite", 32'(memWrite), 1);
    end
    idle();
    checkOutput("wrap last addr", memAddress, 49);
    // Tail is now 2, so the third of these lands in index 0.
    applyStimulus(1'b1, 50, 32'h5A0, 1'b1, 100, 1'b0);
    applyStimulus(1'b1, 51, 32'h5A1, 1'b1, 100, 1'b0);
    applyStimulus(1'b1, 52, 32'h5A2, 1'b1, 100, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 52, 1'b0);
    checkOutput("wrap fwd loadHit", 32'(loadHit), 1);
    checkOutput("wrap fwd loadData", loadData, 32'h5A2);
    for (int i = 0; i < 4; i++) idle();

    // Randomized traffic over a small address range to force many hits.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(99) < 65) ? 1'b1 : 1'b0,
                    $urandom_range(15), $urandom,
                    ($urandom_range(99) < 40) ? 1'b1 : 1'b0,
                    $urandom_range(15),
                    ($urandom_range(199) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) idle();
    for (int i = 0; i < 16; i++) checkOutput("final memory", tbMem[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
